ccc_mem: RTL and testbench

- Word-addressed 1024 x 32-bit data memory for the single-cycle/pipelined CPU datapath; the CPU uses it as the data-memory stage.
- Write port: synchronous, with per-byte enables. Read port: asynchronous (combinational).
- Asynchronous active-low reset clears the whole array to zero.

---
 rtl/ccc_pkg.sv | 17 +
 rtl/ccc_byte_merge.sv | 16 +
 rtl/ccc_mem.sv | 48 ++++
 tb/tb_ccc_mem.sv | 117 +++++++++++
 4 files changed

// File: rtl/ccc_pkg.sv
// Shared constants for the ccc data-memory slice: geometry, reset word and
// the byte-enable patterns used by the CPU store path.
package ccc_pkg;

    localparam int          MEM_DEPTH  = 1024;
    localparam int          WORD_BYTES = 4;
    localparam logic [31:0] RESET_WORD = 32'h0000_0000;

    localparam logic [WORD_BYTES-1:0] BE_WORD    = 4'b1111;
    localparam logic [WORD_BYTES-1:0] BE_HALF_LO = 4'b0011;
    localparam logic [WORD_BYTES-1:0] BE_HALF_HI = 4'b1100;
    localparam logic [WORD_BYTES-1:0] BE_B0      = 4'b0001;
    localparam logic [WORD_BYTES-1:0] BE_B1      = 4'b0010;
    localparam logic [WORD_BYTES-1:0] BE_B2      = 4'b0100;
    localparam logic [WORD_BYTES-1:0] BE_B3      = 4'b1000;

endpackage

// File: rtl/ccc_byte_merge.sv
// Combinational byte-lane merge: lanes with be set take din, others keep old.
// Also used by the CPU store-alignment logic.
module ccc_byte_merge #(
    parameter int NUM_LANES = 4
) (
    input  logic [NUM_LANES-1:0][7:0] old_word,
    input  logic [NUM_LANES-1:0][7:0] din,
    input  logic [NUM_LANES-1:0]      be,
    output logic [NUM_LANES-1:0][7:0] new_word
);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign new_word[i] = be[i] ? din[i] : old_word[i];
    end

endmodule

// File: rtl/ccc_mem.sv
// Word-addressed data memory: synchronous byte-enabled write, combinational
// read, whole array cleared by asynchronous active-low reset.
module ccc_mem
    import ccc_pkg::*;
#(
    parameter int                ADDR_W    = 10,
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VAL = RESET_WORD
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     addr,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [DATA_W-1:0]     din,
    output logic [DATA_W-1:0]     dout,
    output logic                  wr_ack
);

    localparam int DEPTH     = 2 ** ADDR_W;
    localparam int NUM_LANES = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] merged;
    logic              wr_en;

    assign wr_en = we & (|be);
    assign dout  = mem[addr];

    ccc_byte_merge #(.NUM_LANES(NUM_LANES)) u_merge (
        .old_word (mem[addr]),
        .din      (din),
        .be       (be),
        .new_word (merged)
    );

    // Reset is a flop-level clear of every word so dout is valid immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
            wr_ack <= 1'b0;
        end else begin
            if (wr_en) mem[addr] <= merged;
            wr_ack <= wr_en;
        end
    end

endmodule

// File: tb/tb_ccc_mem.sv
// Directed self-checking bench for ccc_mem: reset, full/byte writes,
// boundary addresses, no-op writes and asynchronous reset mid-operation.
module tb_ccc_mem;

    logic        clk;
    logic        rst_n;
    logic [9:0]  addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] din;
    logic [31:0] dout;
    logic        wr_ack;

    int n_chk  = 0;
    int n_fail = 0;

    ccc_mem dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .addr   (addr),
        .we     (we),
        .be     (be),
        .din    (din),
        .dout   (dout),
        .wr_ack (wr_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one write cycle at the falling edge, clock it, then drop we.
    task automatic do_write(input logic [9:0] a, input logic [31:0] d,
                            input logic [3:0] b, input logic w);
        @(negedge clk);
        addr = a; din = d; be = b; we = w;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [9:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, dout, exp);
    endtask

    initial begin
        rst_n = 1'b0; addr = '0; we = 1'b0; be = '0; din = '0;
        #50;
        chk("reset_dout_during", dout, 32'h0);
        chk("reset_ack_during", {31'b0, wr_ack}, 32'h0);
        #50;
        rst_n = 1'b1;
        rd("reset_a0",    10'd0,    32'h0);
        rd("reset_a1",    10'd1,    32'h0);
        rd("reset_a511",  10'd511,  32'h0);
        rd("reset_a1023", 10'd1023, 32'h0);
        chk("reset_ack", {31'b0, wr_ack}, 32'h0);

        do_write(10'h005, 32'hDEAD_BEEF, 4'hF, 1'b1);
        chk("full_ack", {31'b0, wr_ack}, 32'h1);
        chk("full_dout", dout, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        chk("full_ack_pulse", {31'b0, wr_ack}, 32'h0);
        rd("full_neighbor", 10'h006, 32'h0);

        // Old word must remain visible until the edge (no bypass).
        @(negedge clk);
        addr = 10'h005; din = 32'h1122_3344; be = 4'b0010; we = 1'b1;
        #1;
        chk("no_bypass", dout, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        we = 1'b0;
        chk("byte1_dout", dout, 32'hDEAD_33EF);
        do_write(10'h005, 32'hAABB_0000, 4'b1100, 1'b1);
        chk("half_hi_dout", dout, 32'hAABB_33EF);

        do_write(10'h3FF, 32'h8000_0001, 4'hF, 1'b1);
        do_write(10'h000, 32'h0000_0007, 4'hF, 1'b1);
        rd("bound_hi", 10'h3FF, 32'h8000_0001);
        rd("bound_lo", 10'h000, 32'h0000_0007);
        rd("bound_a5", 10'h005, 32'hAABB_33EF);

        do_write(10'h005, 32'hFFFF_FFFF, 4'h0, 1'b1);
        chk("noop_be0_ack", {31'b0, wr_ack}, 32'h0);
        chk("noop_be0_dout", dout, 32'hAABB_33EF);
        do_write(10'h005, 32'h0123_4567, 4'hF, 1'b0);
        chk("noop_we0_ack", {31'b0, wr_ack}, 32'h0);
        chk("noop_we0_dout", dout, 32'hAABB_33EF);

        // Reset asserted between edges must clear the array immediately.
        @(negedge clk);
        addr = 10'h005;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_dout", dout, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rd("post_rst_a5",   10'h005, 32'h0);
        rd("post_rst_a0",   10'h000, 32'h0);
        rd("post_rst_a3ff", 10'h3FF, 32'h0);
        chk("post_rst_ack", {31'b0, wr_ack}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
